// File: rtl/store_merge.sv
// rtl/store_merge.sv - byte/halfword store via read-modify-write of a 32-bit word memory
module store_merge #(
  parameter logic BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t      state, next_state;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  size_q;
  logic [31:0] merge_q;

  logic        word_ok, half_ok, byte_ok;
  logic [4:0]  lane_lo;
  logic [31:0] lane_mask, lane_data, merged;

  assign word_ok = (size == 2'b10) && (addr[1:0] == 2'b00);
  assign half_ok = (size == 2'b01) && !addr[0];
  assign byte_ok = (size == 2'b00);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_ok)                 next_state = WRITE;
          else if (half_ok || byte_ok) next_state = READ;
          else                         next_state = ERR;
        end
      end
      READ:    if (mem_rvalid) next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lane position is the bit offset of the replaced field inside the fetched word.
  always_comb begin
    if (size_q == 2'b00) begin
      lane_lo   = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
      lane_mask = 32'h0000_00ff;
      lane_data = {24'd0, wdata_q[7:0]};
    end else begin
      lane_lo   = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
      lane_mask = 32'h0000_ffff;
      lane_data = {16'd0, wdata_q};
    end
    merged = (mem_rdata & ~(lane_mask << lane_lo)) | (lane_data << lane_lo);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 16'd0;
      size_q  <= 2'b00;
      merge_q <= 32'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        addr_q  <= addr;
        wdata_q <= wdata[15:0];
        size_q  <= size;
        if (word_ok) merge_q <= wdata;
      end
      if (state == READ && mem_rvalid) merge_q <= merged;
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = merge_q;
  assign mem_re    = (state == READ);
  assign mem_we    = (state == WRITE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_store_merge.sv
// tb/tb_store_merge.sv - directed bench for store_merge, both endian builds side by side
module tb_store_merge;

  logic        clk, rst_n, start, mem_rvalid;
  logic [31:0] addr, wdata, mem_rdata;
  logic [1:0]  size;

  logic [31:0] mem_addr_b, mem_wdata_b, mem_addr_l, mem_wdata_l;
  logic        mem_re_b, mem_we_b, busy_b, done_b, err_b;
  logic        mem_re_l, mem_we_l, busy_l, done_l, err_l;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        e_re, e_we, e_done, e_err, e_wz;
  logic [31:0] e_addr, e_wd_be, e_wd_le;

  store_merge #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata), .size(size),
    .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  store_merge #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata), .size(size),
    .mem_addr(mem_addr_l), .mem_re(mem_re_l), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_we(mem_we_l), .mem_wdata(mem_wdata_l), .busy(busy_l), .done(done_l), .err(err_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Store result computed on a memory-ordered byte array rather than on bit lanes.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [31:0] rd,
                                        input bit be);
    logic [7:0]  b [4];
    logic [31:0] r;
    int k;
    if (sz == 2'b10) return wd;
    for (int i = 0; i < 4; i++) b[i] = be ? rd[31-8*i -: 8] : rd[8*i +: 8];
    if (sz == 2'b00) begin
      k = int'(a[1:0]);
      b[k] = wd[7:0];
    end else begin
      k = a[1] ? 2 : 0;
      if (be) begin b[k] = wd[15:8]; b[k+1] = wd[7:0]; end
      else    begin b[k] = wd[7:0];  b[k+1] = wd[15:8]; end
    end
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (be) r[31-8*i -: 8] = b[i];
      else    r[8*i +: 8]    = b[i];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_re_be",   {31'd0, mem_re_b}, {31'd0, e_re});
      chk("mem_we_be",   {31'd0, mem_we_b}, {31'd0, e_we});
      chk("done_be",     {31'd0, done_b},   {31'd0, e_done});
      chk("err_be",      {31'd0, err_b},    {31'd0, e_err});
      chk("busy_be",     {31'd0, busy_b},   {31'd0, e_re | e_we | e_done | e_err});
      chk("mem_addr_be", mem_addr_b, e_addr);
      chk("mem_re_le",   {31'd0, mem_re_l}, {31'd0, e_re});
      chk("mem_we_le",   {31'd0, mem_we_l}, {31'd0, e_we});
      chk("done_le",     {31'd0, done_l},   {31'd0, e_done});
      chk("err_le",      {31'd0, err_l},    {31'd0, e_err});
      chk("busy_le",     {31'd0, busy_l},   {31'd0, e_re | e_we | e_done | e_err});
      chk("mem_addr_le", mem_addr_l, e_addr);
      chk("re_we_excl",  {31'd0, mem_re_b & mem_we_b}, 32'd0);
      if (e_we) begin
        chk("mem_wdata_be", mem_wdata_b, e_wd_be);
        chk("mem_wdata_le", mem_wdata_l, e_wd_le);
      end
      if (e_wz) begin
        chk("rst_wdata_be", mem_wdata_b, 32'd0);
        chk("rst_wdata_le", mem_wdata_l, 32'd0);
      end
    end
  end

  // Advance one clock and state what the outputs must be after that edge.
  task automatic step(input bit re, input bit we, input bit dn, input bit er,
                      input logic [31:0] ea, input bit wz);
    @(posedge clk);
    #1;
    e_re = re; e_we = we; e_done = dn; e_err = er; e_addr = ea; e_wz = wz;
    chk_en = 1'b1;
  endtask

  task automatic busy_inputs(input bit poke);
    start      = poke;
    addr       = 32'hffff_fffc;
    size       = 2'b10;
    wdata      = 32'h0bad_0bad;
    mem_rvalid = poke;
    mem_rdata  = 32'h5a5a_5a5a;
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                           input logic [31:0] rd, input int waits, input bit poke);
    bit legal, rmw;
    logic [31:0] wa;
    legal = (sz == 2'b00) || (sz == 2'b01 && !a[0]) || (sz == 2'b10 && a[1:0] == 2'b00);
    rmw   = legal && (sz != 2'b10);
    wa    = {a[31:2], 2'b00};
    e_wd_be = model(a, wd, sz, rd, 1'b1);
    e_wd_le = model(a, wd, sz, rd, 1'b0);
    start = 1'b1; addr = a; wdata = wd; size = sz;
    mem_rvalid = 1'b0; mem_rdata = 32'h5a5a_5a5a;
    if (rmw) begin
      step(1, 0, 0, 0, wa, 0);
      for (int i = 0; i <= waits; i++) begin
        busy_inputs(poke);
        mem_rvalid = (i == waits);
        mem_rdata  = (i == waits) ? rd : 32'h5a5a_5a5a;
        step(i != waits, i == waits, 0, 0, wa, 0);
      end
      busy_inputs(poke);
    end else if (legal) begin
      step(0, 1, 0, 0, wa, 0);
      busy_inputs(poke);
    end else begin
      step(0, 0, 0, 1, wa, 0);
      busy_inputs(poke);
    end
    if (legal) begin
      step(0, 0, 1, 0, wa, 0);
      busy_inputs(poke);
    end
    start = 1'b0; mem_rvalid = 1'b0;
    step(0, 0, 0, 0, wa, 0);
  endtask

  task automatic reset_cycle;
    rst_n = 1'b0; start = 1'b1; addr = 32'h400; size = 2'b10; wdata = 32'h1234_5678;
    mem_rvalid = 1'b1; mem_rdata = 32'hcafe_f00d;
    step(0, 0, 0, 0, 32'd0, 1);
    rst_n = 1'b1; start = 1'b0; mem_rvalid = 1'b0;
    step(0, 0, 0, 0, 32'd0, 1);
  endtask

  initial begin
    e_re = 0; e_we = 0; e_done = 0; e_err = 0; e_wz = 0;
    e_addr = 0; e_wd_be = 0; e_wd_le = 0;
    rst_n = 1'b0; start = 1'b0; addr = 0; wdata = 0; size = 0;
    mem_rvalid = 1'b0; mem_rdata = 0;

    chk("pin_be_byte", model(32'h203, 32'h0000_00ab, 2'b00, 32'h1122_3344, 1'b1), 32'h1122_33ab);
    chk("pin_be_half", model(32'h202, 32'hffff_8001, 2'b01, 32'h1122_3344, 1'b1), 32'h1122_8001);
    chk("pin_le_half", model(32'h202, 32'hffff_8001, 2'b01, 32'h1122_3344, 1'b0), 32'h8001_3344);
    chk("pin_le_byte", model(32'h201, 32'h0000_00ab, 2'b00, 32'h1122_3344, 1'b0), 32'h1122_ab44);

    step(0, 0, 0, 0, 32'd0, 1);
    reset_cycle();

    run_store(32'h100, 32'hdead_beef, 2'b10, 32'h0, 0, 0);
    run_store(32'h203, 32'h0000_00ab, 2'b00, 32'h1122_3344, 2, 0);
    run_store(32'h202, 32'hffff_8001, 2'b01, 32'h1122_3344, 0, 0);
    run_store(32'h200, 32'h0000_7e55, 2'b01, 32'haabb_ccdd, 1, 0);
    run_store(32'h201, 32'h0000_1111, 2'b01, 32'h0, 0, 0);
    run_store(32'h102, 32'h2222_2222, 2'b10, 32'h0, 0, 0);
    run_store(32'h300, 32'h3333_3333, 2'b11, 32'h0, 0, 0);
    run_store(32'h040, 32'h0bee_f00d, 2'b10, 32'h0, 0, 1);
    run_store(32'h041, 32'h0000_00c3, 2'b00, 32'h0102_0304, 1, 1);
    run_store(32'h302, 32'h0000_abcd, 2'b01, 32'hffff_ffff, 3, 1);
    run_store(32'h140, 32'h600d_cafe, 2'b10, 32'h0, 0, 0);

    start = 1'b1; addr = 32'h20; wdata = 32'h0000_0099; size = 2'b00;
    step(1, 0, 0, 0, 32'h20, 0);
    start = 1'b0;
    reset_cycle();
    run_store(32'h044, 32'h0a0b_0c0d, 2'b10, 32'h0, 0, 0);

    start = 1'b1; addr = 32'h80; wdata = 32'h7777_8888; size = 2'b10;
    e_wd_be = 32'h7777_8888; e_wd_le = 32'h7777_8888;
    step(0, 1, 0, 0, 32'h80, 0);
    start = 1'b0;
    reset_cycle();
    run_store(32'h0ff, 32'h0000_005e, 2'b00, 32'h8899_aabb, 0, 0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
